// File: rtl/key_sched_pkg.sv
// Shared state encoding and widths for the key scheduler.
package key_sched_pkg;

    localparam int STATE_W = 2;
    localparam int FAIL_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        RUN     = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

endpackage

// File: rtl/key_idx_ctr.sv
// Wrapping bit-index counter for the key schedule; clear beats step,
// and the index is held at zero whenever the schedule is not running.
module key_idx_ctr #(
    parameter int KEY_W = 8,
    parameter int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    output logic [IDX_W-1:0] next_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(KEY_W - 1);

    logic [IDX_W-1:0] idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_idx = idx;
        if (!run || clear) begin
            next_idx = '0;
        end else if (step) begin
            next_idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx <= '0;
        else     idx <= next_idx;
    end

endmodule

// File: rtl/key_sched.sv
// Key scheduler: loads a candidate key, checks it against GOLDEN_KEY and
// serialises it LSB first on step. Define KEY_SCHED_LOCKOUT_EN for tamper lockout.
module key_sched
    import key_sched_pkg::*;
#(
    parameter int               KEY_W      = 8,
    parameter logic [KEY_W-1:0] GOLDEN_KEY = 8'hA5,
    parameter int               MAX_FAIL   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              step,
    input  logic              clear,
    output logic              key_bit,
    output logic              unlocked,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam int                IDX_W    = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [FAIL_W-1:0] FAIL_SAT = '1;

    if (KEY_W < 2 || KEY_W > 32 || MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_param_check
        $error("key_sched: KEY_W or MAX_FAIL out of range");
    end

    state_t            state;
    state_t            state_next;
    logic [KEY_W-1:0]  key_reg;
    logic [IDX_W-1:0]  next_idx;
    logic              key_match;
    logic              lock_hit;
    logic [FAIL_W-1:0] fail_inc;
    logic              ready_d;
    logic              key_bit_d;
    logic              unlocked_d;
    logic              locked_out_d;
    logic [FAIL_W-1:0] fail_d;

    assign key_match = (key_reg == GOLDEN_KEY);
    assign fail_inc  = (fail_cnt == FAIL_SAT) ? fail_cnt : fail_cnt + 1'b1;

`ifdef KEY_SCHED_LOCKOUT_EN
    assign lock_hit = (fail_inc == FAIL_W'(MAX_FAIL));
`else
    assign lock_hit = 1'b0;
`endif

    key_idx_ctr #(
        .KEY_W (KEY_W),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .run      (state == RUN),
        .step     (step),
        .clear    (clear),
        .next_idx (next_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (key_valid) state_next = CHECK;
            CHECK: begin
                if (clear)                      state_next = IDLE;
                else if (!key_match && lock_hit) state_next = LOCKOUT;
                else                            state_next = RUN;
            end
            RUN:     if (clear) state_next = IDLE;
            default: state_next = state;  // LOCKOUT is left only through reset
        endcase
    end

    // Outputs are computed one edge early so they can all be registered.
    always_comb begin
        ready_d      = (state_next == IDLE);
        key_bit_d    = (state_next == RUN) && key_reg[next_idx];
        unlocked_d   = unlocked;
        fail_d       = fail_cnt;
`ifdef KEY_SCHED_LOCKOUT_EN
        locked_out_d = (state_next == LOCKOUT);
`else
        locked_out_d = 1'b0;
`endif
        if (state == CHECK && !clear) begin
            unlocked_d = key_match;
            fail_d     = key_match ? '0 : fail_inc;
        end else if (state_next == IDLE) begin
            unlocked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg    <= '0;
            key_ready  <= 1'b1;
            key_bit    <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
        end else begin
            if (state == IDLE && key_valid) key_reg <= key_data;
            key_ready  <= ready_d;
            key_bit    <= key_bit_d;
            unlocked   <= unlocked_d;
            locked_out <= locked_out_d;
            fail_cnt   <= fail_d;
        end
    end

endmodule

// File: tb/tb_key_sched.sv
// Self-checking bench for key_sched: directed scenarios plus randomized traffic
// against a transaction-level model of the key scheduler.
module tb_key_sched;

    localparam int         KEY_W    = 8;
    localparam logic [7:0] GOLDEN   = 8'hA5;
    localparam int         MAX_FAIL = 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data  = 8'h00;
    logic       step      = 1'b0;
    logic       clear     = 1'b0;
    logic       key_ready;
    logic       key_bit;
    logic       unlocked;
    logic       locked_out;
    logic [3:0] fail_cnt;

    key_sched #(
        .KEY_W      (KEY_W),
        .GOLDEN_KEY (GOLDEN),
        .MAX_FAIL   (MAX_FAIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_data   (key_data),
        .step       (step),
        .clear      (clear),
        .key_bit    (key_bit),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which phase we are in, the loaded key, the bit position
    // being presented and the running count of failed attempts.
    typedef enum {M_IDLE, M_CHECK, M_RUN, M_LOCK} mode_t;
    mode_t m_mode  = M_IDLE;
    int    m_key   = 0;
    int    m_pos   = 0;
    int    m_fails = 0;
    bit    m_unl   = 1'b0;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_key   = 0;
        m_pos   = 0;
        m_fails = 0;
        m_unl   = 1'b0;
    endtask

    task automatic model_update(input bit v, input logic [7:0] d, input bit s, input bit c);
        case (m_mode)
            M_IDLE: if (v) begin
                m_key  = int'(d);
                m_mode = M_CHECK;
            end
            M_CHECK: begin
                if (c) begin
                    m_mode = M_IDLE;
                    m_unl  = 1'b0;
                end else if (m_key == int'(GOLDEN)) begin
                    m_unl   = 1'b1;
                    m_fails = 0;
                    m_pos   = 0;
                    m_mode  = M_RUN;
                end else begin
                    m_unl   = 1'b0;
                    m_fails = (m_fails >= 15) ? 15 : m_fails + 1;
                    m_pos   = 0;
                    m_mode  = M_RUN;
`ifdef KEY_SCHED_LOCKOUT_EN
                    if (m_fails == MAX_FAIL) m_mode = M_LOCK;
`endif
                end
            end
            M_RUN: begin
                if (c) begin
                    m_mode = M_IDLE;
                    m_unl  = 1'b0;
                    m_pos  = 0;
                end else if (s) begin
                    m_pos = (m_pos + 1) % KEY_W;
                end
            end
            default: ;
        endcase
    endtask

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("key_ready",  key_ready,  m_mode == M_IDLE);
            check("key_bit",    key_bit,    (m_mode == M_RUN) ? ((m_key >> m_pos) & 1) : 0);
            check("unlocked",   unlocked,   m_unl);
            check("locked_out", locked_out, m_mode == M_LOCK);
            check("fail_cnt",   fail_cnt,   m_fails);
        end
    end

    // One clock cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit s, input bit c);
        key_valid = v;
        key_data  = d;
        step      = s;
        clear     = c;
        @(posedge clk);
        model_update(v, d, s, c);
        #1;
    endtask

    // Reset raised between clock edges; outputs must drop before the next edge.
    task automatic async_reset();
        key_valid = 1'b0;
        step      = 1'b0;
        clear     = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_key_ready",  key_ready,  1);
        check("rst_key_bit",    key_bit,    0);
        check("rst_unlocked",   unlocked,   0);
        check("rst_locked_out", locked_out, 0);
        check("rst_fail_cnt",   fail_cnt,   0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [0:7] seq;
    int         r;
    bit         rv, rs, rc;
    logic [7:0] rd;

    initial begin
        seq = 8'b1010_0101;  // expected key_bit for idx 0..7 when key is 8'hA5
        model_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        check("init_key_ready", key_ready, 1);
        check("init_fail_cnt",  fail_cnt,  0);

        // Golden key: one CHECK cycle, then serialise LSB first and wrap.
        cycle(1'b1, GOLDEN, 1'b0, 1'b0);
        check("check_key_ready", key_ready, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("golden_unlocked", unlocked, 1);
        check("golden_fail_cnt", fail_cnt, 0);
        check("golden_bit0",     key_bit,  seq[0]);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("golden_step_bit", key_bit, seq[k % 8]);
        end

        // Advance to idx 3, then clear and step together.
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("idx3_bit", key_bit, seq[3]);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("clr_key_ready", key_ready, 1);
        check("clr_key_bit",   key_bit,   0);
        check("clr_unlocked",  unlocked,  0);
        check("clr_fail_cnt",  fail_cnt,  0);
        cycle(1'b1, GOLDEN, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("reentry_bit0", key_bit, 1);

        // All-zero key: mismatch, one failure, zero bits throughout.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("zero_unlocked", unlocked, 0);
        check("zero_fail_cnt", fail_cnt, 1);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("zero_step_bit", key_bit, 0);
        end

        // Asynchronous reset in the middle of a schedule.
        async_reset();

`ifdef KEY_SCHED_LOCKOUT_EN
        for (int n = 1; n <= 3; n++) begin
            cycle(1'b1, 8'h3C, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            if (n < 3) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        check("lock_locked_out", locked_out, 1);
        check("lock_key_ready",  key_ready,  0);
        check("lock_fail_cnt",   fail_cnt,   3);
        cycle(1'b1, GOLDEN, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("lock_ignores_key", unlocked,  0);
        check("lock_holds",       locked_out, 1);
        async_reset();
`else
        for (int n = 1; n <= 16; n++) begin
            cycle(1'b1, 8'h3C, 1'b0, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
            check("sat_fail_cnt", fail_cnt, (n > 15) ? 15 : n);
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        check("sat_locked_out", locked_out, 0);
`endif

        // Randomized traffic; the model tracks every cycle.
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r < 4) ? GOLDEN : (r < 5) ? 8'h00 : 8'($urandom);
            rv = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 9) == 0) && (m_mode != M_CHECK);
            if ($urandom_range(0, 299) == 0) async_reset();
            else                             cycle(rv, rd, rs, rc);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
